// File: rtl/golden_nonce_reporter.sv
// Captures each new golden_nonce into a small FIFO and serialises it as a
// six-byte frame (SYNC, four nonce bytes MSB first, XOR checksum) on a valid/ready byte stream.
module golden_nonce_reporter #(
    parameter int         DEPTH     = 4,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                golden_nonce,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [7:0]                 dropped_count
);
    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, SYNC, B3, B2, B1, B0, CSUM} state_t;

    // Byte stream: a byte moves when tx_valid & tx_ready are both high at a
    // rising edge; tx_data is held unchanged while tx_valid & !tx_ready.
    state_t          state_q, state_d;
    logic [31:0]     frame_q, frame_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [31:0]     last_q, last_d;
    logic [7:0]      dropped_q, dropped_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [31:0]     mem_q [DEPTH];

    logic change, full, empty, hs, pop, push;
    logic [31:0] head;

    assign change   = golden_nonce != last_q;
    assign full     = count_q == FULL_CNT;
    assign empty    = count_q == '0;
    assign tx_valid = state_q != IDLE;
    assign hs       = tx_valid & tx_ready;
    assign pop      = !empty && (state_q == IDLE || (state_q == CSUM && hs));
    // A full FIFO still takes the new nonce when the head leaves this cycle.
    assign push     = change && (!full || pop);
    assign head     = mem_q[rd_ptr_q];

    assign tx_data       = tx_data_q;
    assign fifo_level    = count_q;
    assign dropped_count = dropped_q;

    always_comb begin
        last_d    = golden_nonce;
        wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d   = count_q;
        if (push && !pop) count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
        dropped_d = dropped_q;
        if (change && !push && dropped_q != 8'hFF) dropped_d = dropped_q + 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        tx_data_d = tx_data_q;
        case (state_q)
            IDLE: begin
                tx_data_d = 8'h00;
                if (pop) begin
                    frame_d   = head;
                    state_d   = SYNC;
                    tx_data_d = SYNC_BYTE;
                end
            end
            SYNC: if (hs) begin state_d = B3; tx_data_d = frame_q[31:24]; end
            B3:   if (hs) begin state_d = B2; tx_data_d = frame_q[23:16]; end
            B2:   if (hs) begin state_d = B1; tx_data_d = frame_q[15:8]; end
            B1:   if (hs) begin state_d = B0; tx_data_d = frame_q[7:0]; end
            B0: if (hs) begin
                state_d   = CSUM;
                tx_data_d = frame_q[31:24] ^ frame_q[23:16] ^ frame_q[15:8] ^ frame_q[7:0];
            end
            CSUM: if (hs) begin
                if (pop) begin
                    frame_d   = head;
                    state_d   = SYNC;
                    tx_data_d = SYNC_BYTE;
                end else begin
                    state_d   = IDLE;
                    tx_data_d = 8'h00;
                end
            end
            default: begin
                state_d   = IDLE;
                tx_data_d = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            frame_q   <= '0;
            tx_data_q <= '0;
            last_q    <= '0;
            dropped_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            tx_data_q <= tx_data_d;
            last_q    <= last_d;
            dropped_q <= dropped_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= golden_nonce;
    end
endmodule

// File: tb/tb_golden_nonce_reporter.sv
// Directed bench for golden_nonce_reporter: frame timing, backpressure,
// back-to-back frames, overflow/drop counting, reset mid-frame and zero return.
module tb_golden_nonce_reporter;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   golden_nonce;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [LW-1:0] fifo_level;
    logic [7:0]    dropped_count;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    always #5 clk = ~clk;

    golden_nonce_reporter #(.DEPTH(DEPTH), .SYNC_BYTE(8'hA5)) dut (
        .clk          (clk),
        .rst          (rst),
        .golden_nonce (golden_nonce),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .fifo_level   (fifo_level),
        .dropped_count(dropped_count)
    );

    // Record every byte that is accepted at the following rising edge.
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) got_q.push_back(tx_data);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void push_frame(input logic [31:0] n);
        exp_q.push_back(8'hA5);
        exp_q.push_back(n[31:24]);
        exp_q.push_back(n[23:16]);
        exp_q.push_back(n[15:8]);
        exp_q.push_back(n[7:0]);
        exp_q.push_back(n[31:24] ^ n[23:16] ^ n[15:8] ^ n[7:0]);
    endfunction

    task automatic do_reset();
        rst          = 1'b1;
        golden_nonce = 32'h0;
        tx_ready     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_bytes(input int n, input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (got_q.size() >= n) break;
            step();
        end
        if (got_q.size() >= n) timed_out = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; golden_nonce = 32'h0; tx_ready = 1'b1;
        #3;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        checks++; if (fifo_level !== '0) begin errors++; $display("FAIL reset_fifo_level: got %0d want 0", fifo_level); end
        checks++; if (dropped_count !== 8'h00) begin errors++; $display("FAIL reset_dropped: got %0d want 0", dropped_count); end
    endtask

    task automatic test_basic_frame();
        logic [7:0] e [6];
        e = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        do_reset();
        tx_ready = 1'b1;
        golden_nonce = 32'h12345678;
        step();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL basic_n1_valid: got %b want 0", tx_valid); end
        checks++; if (fifo_level !== LW'(1)) begin errors++; $display("FAIL basic_n1_level: got %0d want 1", fifo_level); end
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== e[i]) begin
                errors++;
                $display("FAIL basic_byte%0d: got valid=%b data=%h want valid=1 data=%h", i, tx_valid, tx_data, e[i]);
            end
        end
        step();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL basic_end_valid: got %b want 0", tx_valid); end
    endtask

    task automatic test_backpressure();
        bit pat [4];
        bit prev_stall;
        bit to;
        logic [7:0] prev_data;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        push_frame(32'h12345678);
        golden_nonce = 32'h12345678;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        for (int c = 0; c < 60 && got_q.size() < 6; c++) begin
            tx_ready = pat[c % 4];
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if (tx_data !== prev_data) begin
                    errors++;
                    $display("FAIL bp_stable: got %h want %h", tx_data, prev_data);
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            @(posedge clk);
            #1;
        end
        tx_ready = 1'b1;
        wait_bytes(6, 10, to);
        repeat (4) step();
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL bp_count: got %0d bytes want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_byte%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        tx_ready = 1'b1;
        push_frame(32'h00000001);
        push_frame(32'h00000002);
        golden_nonce = 32'h00000001;
        step();
        golden_nonce = 32'h00000002;
        step();
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_byte%0d: got valid=%b data=%h want valid=1 data=%h", i, tx_valid, tx_data, exp_q[i]);
            end
            step();
        end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid: got %b want 0", tx_valid); end
    endtask

    task automatic test_overflow();
        logic [31:0] ov [6];
        bit to;
        ov = '{32'h01020304, 32'hCAFEF00D, 32'h80000001, 32'h0000FFFF, 32'h7E7E7E7E, 32'h13579BDF};
        do_reset();
        tx_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            golden_nonce = ov[k];
            step();
        end
        checks++; if (fifo_level !== LW'(4)) begin errors++; $display("FAIL ovf_level: got %0d want 4", fifo_level); end
        checks++; if (dropped_count !== 8'd1) begin errors++; $display("FAIL ovf_dropped: got %0d want 1", dropped_count); end
        for (int k = 0; k < 5; k++) push_frame(ov[k]);
        tx_ready = 1'b1;
        wait_bytes(30, 100, to);
        checks++; if (to) begin errors++; $display("FAIL ovf_timeout: got %0d bytes want 30", got_q.size()); end
        repeat (8) step();
        checks++; if (got_q.size() !== 30) begin errors++; $display("FAIL ovf_count: got %0d bytes want 30", got_q.size()); end
        checks++; if (fifo_level !== '0) begin errors++; $display("FAIL ovf_drain_level: got %0d want 0", fifo_level); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL ovf_byte%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_drop_saturate();
        do_reset();
        tx_ready = 1'b0;
        for (int i = 1; i <= 262; i++) begin
            golden_nonce = 32'(i);
            step();
        end
        checks++; if (dropped_count !== 8'hFF) begin errors++; $display("FAIL sat_dropped: got %0d want 255", dropped_count); end
        checks++; if (fifo_level !== LW'(4)) begin errors++; $display("FAIL sat_level: got %0d want 4", fifo_level); end
    endtask

    task automatic test_reset_mid_frame();
        int valid_cycles;
        bit to;
        do_reset();
        tx_ready = 1'b1;
        golden_nonce = 32'hA1B2C3D4;
        step();
        golden_nonce = 32'h11223344;
        step();
        golden_nonce = 32'h55667788;
        step();
        step();
        step();
        checks++; if (tx_data !== 8'hC3) begin errors++; $display("FAIL rmf_pre_byte: got %h want c3", tx_data); end
        checks++; if (fifo_level !== LW'(2)) begin errors++; $display("FAIL rmf_pre_level: got %0d want 2", fifo_level); end
        rst = 1'b1;
        golden_nonce = 32'h0;
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rmf_valid: got %b want 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rmf_data: got %h want 00", tx_data); end
        checks++; if (fifo_level !== '0) begin errors++; $display("FAIL rmf_level: got %0d want 0", fifo_level); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        got_q.delete();
        exp_q.delete();
        valid_cycles = 0;
        for (int i = 0; i < 12; i++) begin
            if (tx_valid !== 1'b0) valid_cycles++;
            step();
        end
        checks++; if (valid_cycles != 0) begin errors++; $display("FAIL rmf_quiet: got %0d valid cycles want 0", valid_cycles); end
        push_frame(32'h0BADF00D);
        golden_nonce = 32'h0BADF00D;
        wait_bytes(6, 20, to);
        repeat (4) step();
        checks++; if (got_q.size() !== 6) begin errors++; $display("FAIL rmf_count: got %0d bytes want 6", got_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rmf_byte%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_zero_return();
        bit to;
        do_reset();
        tx_ready = 1'b1;
        push_frame(32'hDEADBEEF);
        push_frame(32'h00000000);
        golden_nonce = 32'hDEADBEEF;
        step();
        golden_nonce = 32'h00000000;
        wait_bytes(12, 40, to);
        repeat (4) step();
        checks++; if (got_q.size() !== 12) begin errors++; $display("FAIL zero_count: got %0d bytes want 12", got_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL zero_byte%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_drop_saturate();
        test_reset_mid_frame();
        test_zero_return();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
